// File: rtl/fft_pkg.sv
// Shared types and saturating arithmetic for the SDF FFT stages.
// Holds DATA_W/FFT_N, the stage FSM encoding and sat_add/sat_neg.
package fft_pkg;

    localparam int DATA_W = 24;
    localparam int FFT_N  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // a+b (sub=0) or a-b (sub=1) in DATA_W+1 bits, clipped to DATA_W
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic                     sub
    );
        logic signed [DATA_W:0] w_s;
        if (sub)
            w_s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        else
            w_s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (w_s[DATA_W] != w_s[DATA_W-1])
            return w_s[DATA_W] ? S_MIN : S_MAX;
        return w_s[DATA_W-1:0];
    endfunction

    // -a, with the most negative value clipped to S_MAX
    function automatic logic signed [DATA_W-1:0] sat_neg(
        input logic signed [DATA_W-1:0] a
    );
        return (a == S_MIN) ? S_MAX : -a;
    endfunction

endpackage

// File: rtl/bf2_stage_d2_if.sv
// Stream + delay-line bundle of the D=2 butterfly stage.
// slave: the stage; master: upstream source, delay line and sink.
interface bf2_stage_d2_if;

    logic                               in_valid;
    logic signed [fft_pkg::DATA_W-1:0]  din_r;
    logic signed [fft_pkg::DATA_W-1:0]  din_i;
    logic signed [fft_pkg::DATA_W-1:0]  sr_dout_r;
    logic signed [fft_pkg::DATA_W-1:0]  sr_dout_i;
    logic signed [fft_pkg::DATA_W-1:0]  sr_din_r;
    logic signed [fft_pkg::DATA_W-1:0]  sr_din_i;
    logic                               sr_valid;
    logic signed [fft_pkg::DATA_W-1:0]  dout_r;
    logic signed [fft_pkg::DATA_W-1:0]  dout_i;
    logic                               out_valid;
    logic                               frame_sop;

    modport slave (
        input  in_valid, din_r, din_i, sr_dout_r, sr_dout_i,
        output sr_din_r, sr_din_i, sr_valid,
        output dout_r, dout_i, out_valid, frame_sop
    );

    modport master (
        output in_valid, din_r, din_i, sr_dout_r, sr_dout_i,
        input  sr_din_r, sr_din_i, sr_valid,
        input  dout_r, dout_i, out_valid, frame_sop
    );

endinterface

// File: rtl/bf2_cplx_addsub_sat.sv
// Combinational complex a+b and a-b, each component saturated.
// Ports: i_a_*, i_b_* operands; o_sum_*, o_dif_* results.
module bf2_cplx_addsub_sat
    import fft_pkg::*;
(
    input  logic signed [DATA_W-1:0] i_a_r,
    input  logic signed [DATA_W-1:0] i_a_i,
    input  logic signed [DATA_W-1:0] i_b_r,
    input  logic signed [DATA_W-1:0] i_b_i,
    output logic signed [DATA_W-1:0] o_sum_r,
    output logic signed [DATA_W-1:0] o_sum_i,
    output logic signed [DATA_W-1:0] o_dif_r,
    output logic signed [DATA_W-1:0] o_dif_i
);

    assign o_sum_r = sat_add(i_a_r, i_b_r, 1'b0);
    assign o_sum_i = sat_add(i_a_i, i_b_i, 1'b0);
    assign o_dif_r = sat_add(i_a_r, i_b_r, 1'b1);
    assign o_dif_i = sat_add(i_a_i, i_b_i, 1'b1);

endmodule

// File: rtl/bf2_stage_d2.sv
// Radix-2 SDF butterfly, D=2 stage of the 32-point DIF FFT.
// Ports: clk, reset (sync, high), io (bf2_stage_d2_if.slave).
module bf2_stage_d2
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int FRAME  = FFT_N,
    parameter int DELAY  = 2
) (
    input  logic           clk,
    input  logic           reset,
    bf2_stage_d2_if.slave  io
);

    localparam int KW   = $clog2(FRAME);
    localparam int PH_W = $clog2(2 * DELAY);

    typedef logic signed [DATA_W-1:0] smp_t;

    state_t          r_state;
    state_t          w_cur;
    logic [KW-1:0]   r_k;
    logic            r_primed;
    logic            r_vld;
    logic            r_sop;
    smp_t            r_dout_r;
    smp_t            r_dout_i;

    logic            w_acc;
    logic            w_shift;
    logic            w_bfly;
    logic            w_odd;
    logic            w_emit;
    smp_t            w_din_r;
    smp_t            w_din_i;
    smp_t            w_sum_r;
    smp_t            w_sum_i;
    smp_t            w_dif_r;
    smp_t            w_dif_i;
    smp_t            w_neg_r;
    smp_t            w_cand_r;
    smp_t            w_cand_i;
    smp_t            w_sr_r;
    smp_t            w_sr_i;

    // Effective state of this cycle: accepting a sample counts as RUN
    // even from IDLE, and the RUN cycle that sees in_valid low is the
    // first of the two drain slots.
    always_comb begin
        w_cur = ST_IDLE;
        unique case (1'b1)
            r_state == ST_DRAIN:
                w_cur = ST_DRAIN;
            r_state != ST_DRAIN && io.in_valid:
                w_cur = ST_RUN;
            r_state == ST_RUN && !io.in_valid:
                w_cur = ST_DRAIN;
            default:
                w_cur = ST_IDLE;
        endcase
    end

    assign w_acc   = !reset && (w_cur == ST_RUN);
    assign w_shift = !reset && (w_cur != ST_IDLE);
    assign w_bfly  = r_k[PH_W-1];
    assign w_odd   = r_k[0];

    assign w_din_r = w_acc ? io.din_r : '0;
    assign w_din_i = w_acc ? io.din_i : '0;

    bf2_cplx_addsub_sat u_addsub (
        .i_a_r   (io.sr_dout_r),
        .i_a_i   (io.sr_dout_i),
        .i_b_r   (w_din_r),
        .i_b_i   (w_din_i),
        .o_sum_r (w_sum_r),
        .o_sum_i (w_sum_i),
        .o_dif_r (w_dif_r),
        .o_dif_i (w_dif_i)
    );

    assign w_neg_r = sat_neg(io.sr_dout_r);

    // Fill slots forward the stored difference (times 1 or -j) and
    // park the new sample; butterfly slots emit the sum and park
    // the difference.
    always_comb begin
        w_cand_r = io.sr_dout_r;
        w_cand_i = io.sr_dout_i;
        w_sr_r   = w_din_r;
        w_sr_i   = w_din_i;
        unique case (1'b1)
            w_bfly: begin
                w_cand_r = w_sum_r;
                w_cand_i = w_sum_i;
                w_sr_r   = w_dif_r;
                w_sr_i   = w_dif_i;
            end
            !w_bfly && w_odd: begin
                w_cand_r = io.sr_dout_i;
                w_cand_i = w_neg_r;
            end
            default: begin
                w_cand_r = io.sr_dout_r;
                w_cand_i = io.sr_dout_i;
            end
        endcase
    end

    assign io.sr_valid = w_shift;
    assign io.sr_din_r = w_shift ? w_sr_r : '0;
    assign io.sr_din_i = w_shift ? w_sr_i : '0;

    // Nothing is stored until the first butterfly of a run, so fill
    // slots (and drains) before that produce no output.
    assign w_emit = w_shift && (r_primed || (w_acc && w_bfly));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_primed <= 1'b0;
            r_vld    <= 1'b0;
            r_sop    <= 1'b0;
            r_dout_r <= '0;
            r_dout_i <= '0;
        end else begin
            r_vld <= w_emit;
            r_sop <= w_acc && (r_k == KW'(2));
            if (w_emit) begin
                r_dout_r <= w_cand_r;
                r_dout_i <= w_cand_i;
            end
            if (w_acc && w_bfly)
                r_primed <= 1'b1;
            if (w_shift)
                r_k <= r_k + KW'(1);
            unique case (w_cur)
                ST_RUN: r_state <= ST_RUN;
                ST_DRAIN: begin
                    if (r_state == ST_RUN) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_k      <= '0;
                        r_primed <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_k      <= '0;
                    r_primed <= 1'b0;
                end
            endcase
        end
    end

    assign io.dout_r    = r_dout_r;
    assign io.dout_i    = r_dout_i;
    assign io.out_valid = r_vld;
    assign io.frame_sop = r_sop;

endmodule

// File: tb/tb_bf2_stage_d2.sv
// Directed bench for bf2_stage_d2 with a 2-deep delay line in the loop.
// Ramp, back-to-back, saturation, abort, reset and lone-sample cases.
module tb_bf2_stage_d2;
    import fft_pkg::*;

    localparam int W = DATA_W;

    typedef struct {
        int                  cyc;
        logic signed [W-1:0] r;
        logic signed [W-1:0] i;
        logic                sop;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_srv = 0;
    obs_t q[$];

    logic signed [W-1:0] d0_r = '0;
    logic signed [W-1:0] d0_i = '0;
    logic signed [W-1:0] d1_r = '0;
    logic signed [W-1:0] d1_i = '0;

    bf2_stage_d2_if bus ();

    bf2_stage_d2 dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    always #5 clk = ~clk;

    assign bus.sr_dout_r = d1_r;
    assign bus.sr_dout_i = d1_i;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sr_valid) begin
            d1_r <= d0_r;
            d1_i <= d0_i;
            d0_r <= bus.sr_din_r;
            d0_i <= bus.sr_din_i;
        end
    end

    always @(negedge clk) begin
        obs_t o;
        if (bus.sr_valid)
            n_srv <= n_srv + 1;
        if (bus.out_valid) begin
            o.cyc = cyc;
            o.r   = bus.dout_r;
            o.i   = bus.dout_i;
            o.sop = bus.frame_sop;
            q.push_back(o);
        end
    end

    // Ramp x_k = k: output j belongs to slot s = j+2 of the frame.
    function automatic int exp_r(input int j);
        int kk;
        kk = (j + 2) % 32;
        case (kk % 4)
            2:       return 8 * (kk / 4) + 2;
            3:       return 8 * (kk / 4) + 4;
            0:       return -2;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_i(input int j);
        int kk;
        kk = (j + 2) % 32;
        return ((kk % 4) == 1) ? 2 : 0;
    endfunction

    task automatic drive(input int r, input int i);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.din_r    = W'(r);
        bus.din_i    = W'(i);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.din_r    = '0;
            bus.din_i    = '0;
        end
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
        end
        n_chk++;
        if (bus.frame_sop !== 1'b0) begin
            n_err++;
            $display("FAIL rst_sop got %b want 0", bus.frame_sop);
        end
        n_chk++;
        if (bus.dout_r !== '0 || bus.dout_i !== '0) begin
            n_err++;
            $display("FAIL rst_dout got %0d,%0d want 0,0",
                     bus.dout_r, bus.dout_i);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.sr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_sr_valid got %b want 0", bus.sr_valid);
        end
        n_chk++;
        if (bus.sr_din_r !== '0 || bus.sr_din_i !== '0) begin
            n_err++;
            $display("FAIL idle_sr_din got %0d,%0d want 0,0",
                     bus.sr_din_r, bus.sr_din_i);
        end
    endtask

    task automatic test_ramp(input string tag);
        int base, sbase, c2, n;
        base  = q.size();
        sbase = n_srv;
        c2    = 0;
        for (int k = 0; k < 32; k++) begin
            drive(k, 0);
            if (k == 2) c2 = cyc;
        end
        idle(6);
        n = q.size() - base;
        n_chk++;
        if (n != 32) begin
            n_err++;
            $display("FAIL %s_count got %0d want 32", tag, n);
        end
        n_chk++;
        if (n_srv - sbase != 34) begin
            n_err++;
            $display("FAIL %s_sr_valid got %0d want 34", tag, n_srv - sbase);
        end
        if (n > 0) begin
            n_chk++;
            if (q[base].cyc != c2 + 1) begin
                n_err++;
                $display("FAIL %s_latency got %0d want %0d",
                         tag, q[base].cyc, c2 + 1);
            end
        end
        for (int j = 0; j < n && j < 32; j++) begin
            n_chk++;
            if (q[base+j].r !== W'(exp_r(j)) || q[base+j].i !== W'(exp_i(j))) begin
                n_err++;
                $display("FAIL %s_val[%0d] got %0d,%0d want %0d,%0d", tag, j,
                         q[base+j].r, q[base+j].i, exp_r(j), exp_i(j));
            end
            n_chk++;
            if (q[base+j].sop !== (j == 0)) begin
                n_err++;
                $display("FAIL %s_sop[%0d] got %b want %b",
                         tag, j, q[base+j].sop, (j == 0));
            end
        end
    endtask

    task automatic test_back_to_back;
        int base, n;
        base = q.size();
        for (int k = 0; k < 64; k++)
            drive(k % 32, 0);
        idle(6);
        n = q.size() - base;
        n_chk++;
        if (n != 64) begin
            n_err++;
            $display("FAIL b2b_count got %0d want 64", n);
        end
        for (int j = 0; j < n && j < 64; j++) begin
            n_chk++;
            if (q[base+j].cyc != q[base].cyc + j) begin
                n_err++;
                $display("FAIL b2b_gap[%0d] got cyc %0d want %0d",
                         j, q[base+j].cyc, q[base].cyc + j);
            end
            n_chk++;
            if (q[base+j].r !== W'(exp_r(j)) || q[base+j].i !== W'(exp_i(j))) begin
                n_err++;
                $display("FAIL b2b_val[%0d] got %0d,%0d want %0d,%0d", j,
                         q[base+j].r, q[base+j].i, exp_r(j), exp_i(j));
            end
            n_chk++;
            if (q[base+j].sop !== (j == 0 || j == 32)) begin
                n_err++;
                $display("FAIL b2b_sop[%0d] got %b want %b",
                         j, q[base+j].sop, (j == 0 || j == 32));
            end
        end
    endtask

    task automatic test_saturation;
        int base, n;
        int tr[8];
        int ti[8];
        int er[8];
        int ei[8];
        tr = '{8388607, 0, 8388607, 0, 0, -8388608, 0, 0};
        ti = '{-8388608, 0, -8388608, -8388608, 0, 0, 0, 0};
        er = '{8388607, 0, 0, 8388607, 0, -8388608, 0, 0};
        ei = '{-8388608, -8388608, 0, 0, 0, 0, 0, 8388607};
        base = q.size();
        for (int k = 0; k < 8; k++)
            drive(tr[k], ti[k]);
        idle(6);
        n = q.size() - base;
        n_chk++;
        if (n != 8) begin
            n_err++;
            $display("FAIL sat_count got %0d want 8", n);
        end
        for (int j = 0; j < n && j < 8; j++) begin
            n_chk++;
            if (q[base+j].r !== W'(er[j]) || q[base+j].i !== W'(ei[j])) begin
                n_err++;
                $display("FAIL sat_val[%0d] got %0d,%0d want %0d,%0d", j,
                         q[base+j].r, q[base+j].i, er[j], ei[j]);
            end
        end
    endtask

    task automatic test_abort;
        int base, n, c2;
        base = q.size();
        for (int k = 0; k < 14; k++)
            drive(k, 0);
        idle(6);
        n = q.size() - base;
        n_chk++;
        if (n != 14) begin
            n_err++;
            $display("FAIL abort_count got %0d want 14", n);
        end
        for (int j = 0; j < n && j < 14; j++) begin
            int wr, wi;
            wr = (j < 12) ? exp_r(j) : j;
            wi = (j < 12) ? exp_i(j) : 0;
            n_chk++;
            if (q[base+j].r !== W'(wr) || q[base+j].i !== W'(wi)) begin
                n_err++;
                $display("FAIL abort_val[%0d] got %0d,%0d want %0d,%0d", j,
                         q[base+j].r, q[base+j].i, wr, wi);
            end
        end
        base = q.size();
        idle(4);
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || q.size() != base) begin
            n_err++;
            $display("FAIL abort_quiet got %b/%0d want 0/0",
                     bus.out_valid, q.size() - base);
        end
        base = q.size();
        c2   = 0;
        for (int k = 0; k < 4; k++) begin
            drive(k, 0);
            if (k == 2) c2 = cyc;
        end
        idle(6);
        n = q.size() - base;
        n_chk++;
        if (n != 4) begin
            n_err++;
            $display("FAIL restart_count got %0d want 4", n);
        end
        if (n > 0) begin
            n_chk++;
            if (q[base].cyc != c2 + 1 || q[base].sop !== 1'b1) begin
                n_err++;
                $display("FAIL restart_first got cyc %0d sop %b want %0d 1",
                         q[base].cyc, q[base].sop, c2 + 1);
            end
        end
        for (int j = 0; j < n && j < 4; j++) begin
            n_chk++;
            if (q[base+j].r !== W'(exp_r(j)) || q[base+j].i !== W'(exp_i(j))) begin
                n_err++;
                $display("FAIL restart_val[%0d] got %0d,%0d want %0d,%0d", j,
                         q[base+j].r, q[base+j].i, exp_r(j), exp_i(j));
            end
        end
    endtask

    task automatic test_reset_midframe;
        int nb;
        for (int k = 0; k < 21; k++)
            drive(k, 0);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        @(posedge clk);
        #1;
        nb = q.size();
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.sr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_valid got out %b sr %b want 0 0",
                     bus.out_valid, bus.sr_valid);
        end
        n_chk++;
        if (bus.dout_r !== '0 || bus.dout_i !== '0) begin
            n_err++;
            $display("FAIL mrst_dout got %0d,%0d want 0,0",
                     bus.dout_r, bus.dout_i);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        @(negedge clk);
        n_chk++;
        if (q.size() != nb || bus.sr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_quiet got %0d outputs sr %b want 0 0",
                     q.size() - nb, bus.sr_valid);
        end
        test_ramp("post_rst");
    endtask

    task automatic test_single;
        int base, sbase;
        base  = q.size();
        sbase = n_srv;
        drive(7, 3);
        idle(8);
        n_chk++;
        if (q.size() != base) begin
            n_err++;
            $display("FAIL single_out got %0d want 0", q.size() - base);
        end
        n_chk++;
        if (n_srv - sbase != 3) begin
            n_err++;
            $display("FAIL single_sr_valid got %0d want 3", n_srv - sbase);
        end
    endtask

    initial begin
        test_reset();
        test_ramp("ramp");
        test_back_to_back();
        test_saturation();
        test_abort();
        test_reset_midframe();
        test_single();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
